result_uart_tx: RTL and testbench
=================================

Name: result_uart_tx

Overview:
- Sits directly downstream of cpu_top.
- Watches the CPU's halt flag. On halt it captures the 16-bit Result and serialises it as two 8N1 UART frames, low byte first.
- Gives a physical board the same "final result" readout that simulation gets from the halt monitor.
- Pure sequential block: edge detector, capture register, baud counter, bit FSM.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Legal range 2..65535. The counter is 16 bits wide.

Ports:
- clk     input   1   system clock, rising-edge
- reset   input   1   asynchronous, active-high reset
- halt    input   1   halt flag from cpu_top
- result  input   16  cpu_top Result bus
- tx      output  1   UART serial line, idle high
- busy    output  1   high while a transmission is in progress
- done    output  1   high once both bytes have been sent
- cap     output  16  captured result value, for the bench and for debug

Behaviour:
- Reset (async, active-high) values:
  - tx=1, busy=0, done=0, cap=0
  - halt_q=0, state=IDLE, bit counter=0, baud counter=0, byte index=0
- Rising-edge detection:
  - halt_q is registered every clk.
  - A trigger is halt=1 and halt_q=0, sampled at a clk edge.
  - Because halt_q resets to 0, a halt that is already high after reset release triggers once.
- Capture:
  - On a trigger while state=IDLE, at the same edge: cap<=result, busy<=1, done<=0, state<=START, baud counter<=0, byte index<=0.
  - A trigger while busy is ignored. No re-capture, no queueing.
  - halt staying high does not re-trigger.
- FSM states: IDLE, START, DATA, STOP.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=current byte[bit index], LSB first. Each bit is held CLKS_PER_BIT cycles. After bit 7 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
    - If byte index=0: set byte index=1 and go to START. There is no idle gap between frames.
    - If byte index=1: go to IDLE, busy<=0, done<=1.
  - Current byte is cap[7:0] when byte index=0, cap[15:8] when byte index=1.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1.
  - The state or bit advances on the cycle the counter equals CLKS_PER_BIT-1; the counter wraps to 0 on that cycle.
- tx is registered; no combinational path from inputs to tx.
- Latency:
  - tx first goes low in the cycle after the trigger edge.
  - busy falls exactly 20*CLKS_PER_BIT cycles after it rose. done rises on the same edge.
- done stays high until reset or the next accepted trigger.
- Reset mid-transmission: the line returns to idle (tx=1) immediately and asynchronously. The partial frame is abandoned and cap is cleared.
- A new trigger is accepted in the first cycle that state=IDLE, including the cycle right after done rises.
- result changing after capture has no effect on the frame in flight.

Test Plan:
- Basic frame. CLKS_PER_BIT=4, result=16'h1234, halt rises once.
  - Required: cap=1234h, busy high for exactly 80 cycles.
  - tx sequence sampled mid-bit: 0,0,0,1,0,1,1,0,0,1 (34h framed), then 0,0,1,0,0,1,0,0,0,1 (12h framed).
  - done=1 afterwards.
- Halt already high at reset release. halt=1 throughout, result=16'h00FF.
  - Exactly one transmission: bytes FFh then 00h.
  - Afterwards busy=0, done=1, tx=1 indefinitely.
- Trigger while busy. Pulse halt low then high midway through byte 0 with result changed to 16'hBEEF.
  - Required: transmission continues with the original value, cap unchanged, total duration still 80 cycles.
- Reset mid-operation. Assert reset during the DATA state of byte 1.
  - Required: tx=1, busy=0, done=0, cap=0 without waiting for a clk edge.
  - After release with halt=1, a fresh transmission starts.
- Back-to-back. Toggle halt to re-trigger in the first IDLE cycle after done, result=16'hA55A.
  - Required: done clears at the trigger edge, new frames 5Ah then A5h.
- Extremes. CLKS_PER_BIT=2 with result=16'h0000, then 16'hFFFF.
  - Required: correct 40-cycle frames.
  - All-zero data bits are framed by a high stop bit; the stop bits of all-ones frames are indistinguishable from idle until the next start bit.

Source files
------------

// File: rtl/result_uart_tx.sv
// Captures the CPU result on the rising edge of halt and sends it as two
// 8N1 UART frames, low byte first.
module result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        halt,
  input  logic [15:0] result,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [15:0] cap
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic        halt_q;
  logic [2:0]  bit_idx;
  logic [15:0] baud;
  logic        byte_idx;

  logic        trig;
  logic        baud_end;
  logic [7:0]  cur_byte;

  assign trig     = halt & ~halt_q;
  assign baud_end = (baud == BAUD_LAST);
  assign cur_byte = byte_idx ? cap[15:8] : cap[7:0];

  // tx is loaded one bit ahead, so each bit appears the cycle after the
  // edge that moves the FSM into it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      cap      <= 16'h0000;
      halt_q   <= 1'b0;
      state    <= IDLE;
      bit_idx  <= 3'd0;
      baud     <= 16'd0;
      byte_idx <= 1'b0;
    end else begin
      halt_q <= halt;
      case (state)
        IDLE: begin
          if (trig) begin
            cap      <= result;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= START;
            baud     <= 16'd0;
            byte_idx <= 1'b0;
            bit_idx  <= 3'd0;
            tx       <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            baud    <= 16'd0;
            state   <= DATA;
            bit_idx <= 3'd0;
            tx      <= cur_byte[0];
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= 16'd0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud <= 16'd0;
            if (!byte_idx) begin
              // Second frame follows immediately, no idle gap.
              byte_idx <= 1'b1;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx: two instances (4 and 2 clocks per bit) driven
// from a table of frames plus hand-written reset and halt sequences.
module tb_result_uart_tx;

  logic        clk;
  logic        reset;
  logic        halt1, halt2;
  logic [15:0] result;
  logic        tx1, busy1, done1;
  logic        tx2, busy2, done2;
  logic [15:0] cap1, cap2;

  logic        sel;
  logic        tx_s, busy_s, done_s;
  logic [15:0] cap_s;

  int checks;
  int errors;

  result_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(reset), .halt(halt1), .result(result),
    .tx(tx1), .busy(busy1), .done(done1), .cap(cap1)
  );

  result_uart_tx #(.CLKS_PER_BIT(2)) dut2 (
    .clk(clk), .reset(reset), .halt(halt2), .result(result),
    .tx(tx2), .busy(busy2), .done(done2), .cap(cap2)
  );

  assign tx_s   = sel ? tx2   : tx1;
  assign busy_s = sel ? busy2 : busy1;
  assign done_s = sel ? done2 : done1;
  assign cap_s  = sel ? cap2  : cap1;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Line sequences, first bit on the left: start, 8 data LSB first, stop.
  localparam logic [0:19] SEQ_1234 = 20'b0001011001_0010010001;
  localparam logic [0:19] SEQ_00FF = 20'b0111111111_0000000001;
  localparam logic [0:19] SEQ_A55A = 20'b0010110101_0101001011;
  localparam logic [0:19] SEQ_0000 = 20'b0000000001_0000000001;
  localparam logic [0:19] SEQ_FFFF = 20'b0111111111_0111111111;

  typedef struct {
    bit          sel;
    logic [15:0] res;
    logic [0:19] seq;
    bit          trig;
    int          mode;   // 0 plain, 1 halt glitch while busy, 2 arm back-to-back
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_halt(input logic v);
    if (sel) halt2 = v;
    else     halt1 = v;
  endtask

  // Optionally raise halt, then follow one full two-frame transmission,
  // sampling tx mid-bit and counting busy cycles.
  task automatic run_frame(input logic [15:0] res, input logic [0:19] seq,
                           input bit trig, input int mode);
    int n;
    int busy_cnt;
    n = sel ? 2 : 4;
    busy_cnt = 0;
    if (trig) begin
      @(negedge clk);
      set_halt(1'b0);
      repeat (2) @(negedge clk);
      result = res;
      set_halt(1'b1);
    end
    @(posedge clk);
    for (int c = 0; c <= 20 * n; c++) begin
      @(negedge clk);
      if (c == 0) check("done clear at trigger", 32'(done_s), 32'd0);
      if (c < 20 * n) begin
        if (busy_s) busy_cnt++;
        if ((c % n) == (n / 2))
          check($sformatf("tx bit %0d of %0h", c / n, res), 32'(tx_s), 32'(seq[c / n]));
      end
      if (mode == 1 && c == 3 * n) set_halt(1'b0);
      if (mode == 1 && c == 3 * n + 2) begin
        result = 16'hBEEF;
        set_halt(1'b1);
      end
      if (mode == 2 && c == 20 * n - 1) set_halt(1'b0);
    end
    check("busy cycles", 32'(busy_cnt), 32'(20 * n));
    check("busy low after frames", 32'(busy_s), 32'd0);
    check("done high after frames", 32'(done_s), 32'd1);
    check("tx idle after frames", 32'(tx_s), 32'd1);
    check("cap holds captured value", 32'(cap_s), 32'(res));
    if (mode == 2) begin
      result = 16'hA55A;
      set_halt(1'b1);
    end
  endtask

  initial begin
    int bad;
    checks = 0;
    errors = 0;
    sel    = 1'b0;
    reset  = 1'b1;
    halt1  = 1'b1;
    halt2  = 1'b0;
    result = 16'h00FF;

    vecs[0] = '{1'b0, 16'h1234, SEQ_1234, 1'b1, 0};
    vecs[1] = '{1'b0, 16'h1234, SEQ_1234, 1'b1, 1};
    vecs[2] = '{1'b0, 16'h1234, SEQ_1234, 1'b1, 2};
    vecs[3] = '{1'b0, 16'hA55A, SEQ_A55A, 1'b0, 0};
    vecs[4] = '{1'b1, 16'h0000, SEQ_0000, 1'b1, 0};
    vecs[5] = '{1'b1, 16'hFFFF, SEQ_FFFF, 1'b1, 0};

    // Reset values, with halt already high.
    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx1), 32'd1);
    check("reset busy", 32'(busy1), 32'd0);
    check("reset done", 32'(done1), 32'd0);
    check("reset cap", 32'(cap1), 32'd0);

    // Halt high across reset release triggers exactly once.
    reset = 1'b0;
    run_frame(16'h00FF, SEQ_00FF, 1'b0, 0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b1) bad++;
    end
    check("no retrigger while halt held", 32'(bad), 32'd0);

    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      run_frame(vecs[i].res, vecs[i].seq, vecs[i].trig, vecs[i].mode);
    end

    // Reset during byte 1 data bits, then restart with halt held high.
    sel = 1'b0;
    @(negedge clk);
    halt1 = 1'b0;
    repeat (2) @(negedge clk);
    result = 16'h1234;
    halt1  = 1'b1;
    @(posedge clk);
    repeat (57) @(negedge clk);
    check("busy before mid reset", 32'(busy1), 32'd1);
    reset = 1'b1;
    #1;
    check("mid reset tx", 32'(tx1), 32'd1);
    check("mid reset busy", 32'(busy1), 32'd0);
    check("mid reset done", 32'(done1), 32'd0);
    check("mid reset cap", 32'(cap1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_frame(16'h1234, SEQ_1234, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
